ysyx_210544_cache_arbiter: RTL and testbench

Two-master arbiter placed in front of the unaligned-capable cache core. It lets the instruction fetch unit (IFU) and the load/store unit (LSU) share the core's single req/ack port. It grants one transaction at a time, registers the request fields at grant, returns the read data to the owning master, and bounds IFU starvation. A fence input blocks new grants so the pipeline can quiesce before a cache sync or flush.

---
 rtl/ysyx_210544_cache_arbiter_pkg.sv | 40 ++++
 rtl/ysyx_210544_cache_arbiter_if.sv | 47 ++++
 rtl/ysyx_210544_cache_arbiter.sv | 132 +++++++++++++
 tb/tb_ysyx_210544_cache_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_210544_cache_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU cache-core arbiter.
package ysyx_210544_cache_arbiter_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned BYTES_W  = 3;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IFU = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_owner_e;

  // Instruction fetches are always 4-byte reads
  localparam logic [BYTES_W-1:0] IFU_FETCH_BYTES = 3'd3;

  // Request fields presented to the cache core
  typedef struct packed {
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    wdata;
    logic [BYTES_W-1:0] bytes;
    logic               op;
  } core_cmd_t;

  // Build the core command for an instruction fetch
  function automatic core_cmd_t ifu_cmd(input logic [XLEN-1:0] addr);
    core_cmd_t c;
    c.addr  = addr;
    c.wdata = '0;
    c.bytes = IFU_FETCH_BYTES;
    c.op    = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/ysyx_210544_cache_arbiter_if.sv
// Bus bundle around the arbiter: IFU side, LSU side, fence/idle and cache-core side.
interface ysyx_210544_cache_arbiter_if;
  import ysyx_210544_cache_arbiter_pkg::*;

  logic               ifu_req;
  logic [XLEN-1:0]    ifu_addr;
  logic [XLEN-1:0]    ifu_rdata;
  logic               ifu_ack;

  logic               lsu_req;
  logic [XLEN-1:0]    lsu_addr;
  logic [XLEN-1:0]    lsu_wdata;
  logic [BYTES_W-1:0] lsu_bytes;
  logic               lsu_op;
  logic [XLEN-1:0]    lsu_rdata;
  logic               lsu_ack;

  logic               fence;
  logic               idle;

  logic               core_req;
  logic [XLEN-1:0]    core_addr;
  logic [XLEN-1:0]    core_wdata;
  logic [BYTES_W-1:0] core_bytes;
  logic               core_op;
  logic [XLEN-1:0]    core_rdata;
  logic               core_ack;

  // Arbiter view: it masters the cache-core port
  modport master (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_addr, lsu_wdata, lsu_bytes, lsu_op,
    input  fence, core_rdata, core_ack,
    output ifu_rdata, ifu_ack, lsu_rdata, lsu_ack, idle,
    output core_req, core_addr, core_wdata, core_bytes, core_op
  );

  // Environment view: requesting units and the cache core
  modport slave (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_addr, lsu_wdata, lsu_bytes, lsu_op,
    output fence, core_rdata, core_ack,
    input  ifu_rdata, ifu_ack, lsu_rdata, lsu_ack, idle,
    input  core_req, core_addr, core_wdata, core_bytes, core_op
  );

endinterface

// File: rtl/ysyx_210544_cache_arbiter.sv
// Two-master (IFU/LSU) arbiter in front of the cache core, with IFU starvation bound and fence.
module ysyx_210544_cache_arbiter
  import ysyx_210544_cache_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_210544_cache_arbiter_if.master  bus
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  core_cmd_t           cmd_q, cmd_d;
  core_cmd_t           lsu_cmd;
  logic                req_q, req_d;
  logic                ifu_ack_q, ifu_ack_d;
  logic                lsu_ack_q, lsu_ack_d;
  logic                idle_q, idle_d;
  logic [XLEN-1:0]     ifu_rdata_q, ifu_rdata_d;
  logic [XLEN-1:0]     lsu_rdata_q, lsu_rdata_d;
  logic                ifu_wins;

  // LSU fields as they would be latched at grant
  assign lsu_cmd = '{addr: bus.lsu_addr, wdata: bus.lsu_wdata,
                     bytes: bus.lsu_bytes, op: bus.lsu_op};

  // IFU wins only when the LSU is silent or has used up its streak
  assign ifu_wins = bus.ifu_req && (!bus.lsu_req || (streak_q == STREAK_MAX));

  // Next-state, grant selection, completion routing
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    cmd_d       = cmd_q;
    req_d       = req_q;
    ifu_ack_d   = 1'b0;
    lsu_ack_d   = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (!bus.fence && (bus.ifu_req || bus.lsu_req)) begin
          req_d   = 1'b1;
          state_d = ARB_GRANT;
          if (ifu_wins) begin
            owner_d  = ARB_OWN_IFU;
            cmd_d    = ifu_cmd(bus.ifu_addr);
            streak_d = '0;
          end else begin
            owner_d = ARB_OWN_LSU;
            cmd_d   = lsu_cmd;
            if (!bus.ifu_req) begin
              streak_d = '0;
            end else if (streak_q < STREAK_MAX) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end
        end
      end
      ARB_GRANT: begin
        if (bus.core_ack) begin
          req_d   = 1'b0;
          state_d = ARB_DRAIN;
          if (owner_q == ARB_OWN_LSU) begin
            lsu_rdata_d = bus.core_rdata;
            lsu_ack_d   = 1'b1;
          end else begin
            ifu_rdata_d = bus.core_rdata;
            ifu_ack_d   = 1'b1;
          end
        end
      end
      ARB_DRAIN: begin
        // Hold off until the core drops the previous ack
        if (!bus.core_ack) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        req_d   = 1'b0;
      end
    endcase

    idle_d = (state_d == ARB_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWN_IFU;
      streak_q    <= '0;
      cmd_q       <= '0;
      req_q       <= 1'b0;
      ifu_ack_q   <= 1'b0;
      lsu_ack_q   <= 1'b0;
      idle_q      <= 1'b1;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      cmd_q       <= cmd_d;
      req_q       <= req_d;
      ifu_ack_q   <= ifu_ack_d;
      lsu_ack_q   <= lsu_ack_d;
      idle_q      <= idle_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  assign bus.core_req   = req_q;
  assign bus.core_addr  = cmd_q.addr;
  assign bus.core_wdata = cmd_q.wdata;
  assign bus.core_bytes = cmd_q.bytes;
  assign bus.core_op    = cmd_q.op;
  assign bus.ifu_rdata  = ifu_rdata_q;
  assign bus.ifu_ack    = ifu_ack_q;
  assign bus.lsu_rdata  = lsu_rdata_q;
  assign bus.lsu_ack    = lsu_ack_q;
  assign bus.idle       = idle_q;

endmodule

// File: tb/tb_ysyx_210544_cache_arbiter.sv
// Self-checking bench: master/core models, grant/ack scoreboard, vector table and corner sequences.
module tb_ysyx_210544_cache_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_210544_cache_arbiter_if bus();

  ysyx_210544_cache_arbiter #(.MAX_LSU_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        owner;      // 0 = IFU, 1 = LSU
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  bytes;
    logic        op;
  } grant_t;

  typedef struct {
    logic        owner;
    logic [63:0] rdata;
  } ack_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  bytes;
    logic        op;
  } lreq_t;

  typedef struct {
    logic        is_lsu;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  bytes;
    logic        op;
    int          lat;
    logic [63:0] exp_wdata;
    logic [2:0]  exp_bytes;
    logic        exp_op;
  } vec_t;

  grant_t      exp_grant[$];
  ack_t        exp_ack[$];
  logic [63:0] ifu_q[$];
  lreq_t       lsu_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int grant_cyc = 0;
  int core_lat = 3;
  int core_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] core_data(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, ~a[63:32]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_l(input logic [63:0] a, input logic [63:0] w, input logic [2:0] b, input logic o);
    exp_grant.push_back('{owner: 1'b1, addr: a, wdata: w, bytes: b, op: o});
  endtask

  task automatic exp_i(input logic [63:0] a);
    exp_grant.push_back('{owner: 1'b0, addr: a, wdata: 64'd0, bytes: 3'd3, op: 1'b0});
  endtask

  // Cache core: acks core_lat cycles after req, holds ack core_hold cycles past req fall
  initial begin : core_model
    int cnt;
    int hold;
    cnt = 0;
    hold = 0;
    bus.core_ack = 1'b0;
    bus.core_rdata = 64'd0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        bus.core_ack = 1'b0;
        cnt = 0;
        hold = 0;
      end else if (bus.core_ack) begin
        if (!bus.core_req) begin
          if (hold >= core_hold) begin
            bus.core_ack = 1'b0;
            hold = 0;
          end else begin
            hold++;
          end
        end
      end else if (bus.core_req) begin
        cnt++;
        if (cnt >= core_lat) begin
          bus.core_ack = 1'b1;
          bus.core_rdata = core_data(bus.core_addr);
          cnt = 0;
        end
      end
    end
  end

  // IFU: holds req until ack, drops it, raises the next one a cycle later
  initial begin : ifu_drv
    bus.ifu_req = 1'b0;
    bus.ifu_addr = 64'd0;
    forever begin
      @(negedge clk); #1;
      if (bus.ifu_req && bus.ifu_ack) begin
        bus.ifu_req = 1'b0;
      end else if (!bus.ifu_req && ifu_q.size() > 0) begin
        bus.ifu_addr = ifu_q.pop_front();
        bus.ifu_req = 1'b1;
      end
    end
  end

  // LSU: same handshake discipline as the IFU
  initial begin : lsu_drv
    lreq_t r;
    bus.lsu_req = 1'b0;
    bus.lsu_addr = 64'd0;
    bus.lsu_wdata = 64'd0;
    bus.lsu_bytes = 3'd0;
    bus.lsu_op = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (bus.lsu_req && bus.lsu_ack) begin
        bus.lsu_req = 1'b0;
      end else if (!bus.lsu_req && lsu_q.size() > 0) begin
        r = lsu_q.pop_front();
        bus.lsu_addr = r.addr;
        bus.lsu_wdata = r.wdata;
        bus.lsu_bytes = r.bytes;
        bus.lsu_op = r.op;
        bus.lsu_req = 1'b1;
      end
    end
  end

  // Scoreboard: match each core grant and each master ack against expectations
  initial begin : monitor
    grant_t g;
    ack_t a;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0;
      end else begin
        if (bus.core_req && !prev_req) begin
          chk("grant_with_core_ack_low", 64'(bus.core_ack), 64'd0);
          if (exp_grant.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_grant: got addr 0x%0h, want no grant", bus.core_addr);
          end else begin
            g = exp_grant.pop_front();
            chk("grant_addr", bus.core_addr, g.addr);
            chk("grant_wdata", bus.core_wdata, g.wdata);
            chk("grant_bytes", 64'(bus.core_bytes), 64'(g.bytes));
            chk("grant_op", 64'(bus.core_op), 64'(g.op));
            exp_ack.push_back('{owner: g.owner, rdata: core_data(g.addr)});
            grant_cyc = cyc;
          end
        end
        if (bus.ifu_ack || bus.lsu_ack) begin
          chk("single_ack", 64'(bus.ifu_ack & bus.lsu_ack), 64'd0);
          if (exp_ack.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_ack: got ifu=%0d lsu=%0d, want none", bus.ifu_ack, bus.lsu_ack);
          end else begin
            a = exp_ack.pop_front();
            chk("ack_owner", 64'(bus.lsu_ack), 64'(a.owner));
            chk("ack_rdata", a.owner ? bus.lsu_rdata : bus.ifu_rdata, a.rdata);
            chk("ack_latency", 64'(cyc - grant_cyc), 64'(core_lat));
          end
        end
        prev_req = bus.core_req;
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((ifu_q.size() > 0 || lsu_q.size() > 0 || bus.ifu_req || bus.lsu_req ||
            exp_grant.size() > 0 || exp_ack.size() > 0 || !bus.idle) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d cycles, want < %0d (grants left %0d, acks left %0d)",
               name, n, budget, exp_grant.size(), exp_ack.size());
    end
  endtask

  task automatic wait_core_req(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.core_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(bus.core_req), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_grant.delete();
    exp_ack.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin : main
    int t0;
    vecs[0] = '{1'b1, 64'h8000_0008, 64'h0, 3'd7, 1'b0, 3, 64'h0, 3'd7, 1'b0};
    vecs[1] = '{1'b1, 64'h8000_0100, 64'h1122_3344_5566_7788, 3'd3, 1'b1, 1,
                64'h1122_3344_5566_7788, 3'd3, 1'b1};
    vecs[2] = '{1'b0, 64'h8000_0000, 64'h0, 3'd0, 1'b0, 2, 64'h0, 3'd3, 1'b0};
    vecs[3] = '{1'b1, 64'h8000_0203, 64'hFFFF_0000_FFFF_0000, 3'd1, 1'b0, 5,
                64'hFFFF_0000_FFFF_0000, 3'd1, 1'b0};
    vecs[4] = '{1'b0, 64'h8000_0FFC, 64'h0, 3'd0, 1'b0, 1, 64'h0, 3'd3, 1'b0};
    vecs[5] = '{1'b1, 64'h8000_0011, 64'h0000_0000_0000_00AB, 3'd0, 1'b1, 4,
                64'h0000_0000_0000_00AB, 3'd0, 1'b1};
    bus.fence = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_core_req", 64'(bus.core_req), 64'd0);
    chk("rst_core_addr", bus.core_addr, 64'd0);
    chk("rst_core_wdata", bus.core_wdata, 64'd0);
    chk("rst_core_bytes", 64'(bus.core_bytes), 64'd0);
    chk("rst_core_op", 64'(bus.core_op), 64'd0);
    chk("rst_ifu_ack", 64'(bus.ifu_ack), 64'd0);
    chk("rst_lsu_ack", 64'(bus.lsu_ack), 64'd0);
    chk("rst_ifu_rdata", bus.ifu_rdata, 64'd0);
    chk("rst_lsu_rdata", bus.lsu_rdata, 64'd0);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    rst = 1'b1;

    // Single-master transactions from the vector table
    for (int i = 0; i < 6; i++) begin
      core_lat = vecs[i].lat;
      exp_grant.push_back('{owner: vecs[i].is_lsu, addr: vecs[i].addr, wdata: vecs[i].exp_wdata,
                            bytes: vecs[i].exp_bytes, op: vecs[i].exp_op});
      if (vecs[i].is_lsu)
        lsu_q.push_back('{addr: vecs[i].addr, wdata: vecs[i].wdata,
                          bytes: vecs[i].bytes, op: vecs[i].op});
      else
        ifu_q.push_back(vecs[i].addr);
      wait_done("vec", 40);
    end

    // Simultaneous requests from reset: LSU first, then IFU
    do_reset();
    core_lat = 2;
    exp_l(64'h9000_0040, 64'h55, 3'd7, 1'b0);
    exp_i(64'h8000_1000);
    lsu_q.push_back('{addr: 64'h9000_0040, wdata: 64'h55, bytes: 3'd7, op: 1'b0});
    ifu_q.push_back(64'h8000_1000);
    wait_done("simultaneous", 40);

    // Continuous LSU with IFU waiting: L,L,L,L,I,L,L,L,L,I,L
    do_reset();
    core_lat = 1;
    for (int k = 0; k < 9; k++)
      lsu_q.push_back('{addr: 64'h2000_0000 + 64'(k * 8), wdata: 64'(k), bytes: 3'd7, op: 1'b0});
    for (int k = 0; k < 2; k++)
      ifu_q.push_back(64'h1000_0000 + 64'(k * 4));
    begin
      int li;
      int ii;
      li = 0;
      ii = 0;
      for (int k = 0; k < 11; k++) begin
        if (k == 4 || k == 9) begin
          exp_i(64'h1000_0000 + 64'(ii * 4));
          ii++;
        end else begin
          exp_l(64'h2000_0000 + 64'(li * 8), 64'(li), 3'd7, 1'b0);
          li++;
        end
      end
    end
    wait_done("streak", 200);

    // Fence raised during an LSU write: write completes, then no grant until fence drops
    do_reset();
    core_lat = 3;
    exp_l(64'h8000_2000, 64'hCAFE_F00D, 3'd3, 1'b1);
    lsu_q.push_back('{addr: 64'h8000_2000, wdata: 64'hCAFE_F00D, bytes: 3'd3, op: 1'b1});
    wait_core_req("fence_lsu_granted", 10);
    bus.fence = 1'b1;
    exp_i(64'h8000_3000);
    ifu_q.push_back(64'h8000_3000);
    repeat (8) @(negedge clk);
    chk("fence_no_req", 64'(bus.core_req), 64'd0);
    chk("fence_idle", 64'(bus.idle), 64'd1);
    chk("fence_ifu_pending", 64'(exp_grant.size()), 64'd1);
    bus.fence = 1'b0;
    @(negedge clk);
    chk("fence_release_grant", 64'(bus.core_req), 64'd1);
    wait_done("fence", 40);

    // Reset in GRANT: req drops at once, no ack, pending request re-granted afterwards
    do_reset();
    core_lat = 6;
    exp_l(64'h8000_4000, 64'h0, 3'd7, 1'b0);
    lsu_q.push_back('{addr: 64'h8000_4000, wdata: 64'h0, bytes: 3'd7, op: 1'b0});
    wait_core_req("rst_mid_granted", 10);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_req_async", 64'(bus.core_req), 64'd0);
    chk("rst_mid_idle", 64'(bus.idle), 64'd1);
    exp_ack.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid_no_ack", 64'(bus.lsu_ack | bus.ifu_ack), 64'd0);
    end
    core_lat = 2;
    exp_l(64'h8000_4000, 64'h0, 3'd7, 1'b0);
    rst = 1'b1;
    wait_done("rst_mid", 40);

    // Core holds ack 2 cycles past req fall: next grant waits in DRAIN
    do_reset();
    core_lat = 1;
    core_hold = 2;
    exp_l(64'h8000_5000, 64'h0, 3'd7, 1'b0);
    exp_l(64'h8000_5008, 64'h0, 3'd7, 1'b0);
    lsu_q.push_back('{addr: 64'h8000_5000, wdata: 64'h0, bytes: 3'd7, op: 1'b0});
    lsu_q.push_back('{addr: 64'h8000_5008, wdata: 64'h0, bytes: 3'd7, op: 1'b0});
    begin
      int n;
      n = 0;
      while (!bus.lsu_ack && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("drain_first_ack", 64'(bus.lsu_ack), 64'd1);
      t0 = cyc;
      @(negedge clk);
      n = 0;
      while (!bus.core_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("drain_regrant_gap", 64'(cyc - t0), 64'd4);
    end
    wait_done("drain", 40);
    core_hold = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
